// File: rtl/sobel_pkg.sv
// Shared constants and frame-state encoding for the Sobel frame-buffer path.
// Imported by the RAM scheduler and its address counters.
package sobel_pkg;

    localparam int DEF_IMG_W  = 100;
    localparam int DEF_IMG_H  = 100;
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 8;
    localparam int PIX_TOTAL  = DEF_IMG_W * DEF_IMG_H;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

endpackage

// File: rtl/frame_addr_cnt.sv
// Wrapping address counter; addr is the address used this cycle.
// clr forces the current address to 0 (and inc then steps from 0).
module frame_addr_cnt
    import sobel_pkg::*;
#(
    parameter int MAX = PIX_TOTAL,
    parameter int W   = DEF_ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] addr
);

    logic [W-1:0] cnt;
    logic [W-1:0] base;

    assign base = clr ? '0 : cnt;
    assign addr = base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (base == W'(MAX - 1)) ? '0 : base + 1'b1;
        end else begin
            cnt <= base;
        end
    end

endmodule

// File: rtl/frame_ram_sched.sv
// Single-port frame RAM scheduler: read-priority arbiter, frame FSM,
// 3-stage read pipeline with per-read blanking, and write starvation flag.
module frame_ram_sched
    import sobel_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 255
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_frame_start,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              frame_done,
    output logic              wr_starve
);

    localparam int PIX_CNT = IMG_W * IMG_H;
    localparam int SW      = $clog2(STARVE_MAX + 1);

    state_t            state;
    state_t            state_d;
    logic              rd_gnt;
    logic              wr_gnt;
    logic              last_pix;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [1:0]        vld_q;
    logic [1:0]        shw_q;
    logic [SW-1:0]     starve_cnt;

    assign rd_gnt   = rd_req;
    assign wr_gnt   = wr_req & ~rd_req;
    assign wr_ack   = wr_gnt;
    assign last_pix = (waddr == ADDR_W'(PIX_CNT - 1));

    frame_addr_cnt #(.MAX(PIX_CNT), .W(ADDR_W)) u_waddr (
        .clk   (sclk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (wr_gnt),
        .addr  (waddr)
    );

    frame_addr_cnt #(.MAX(PIX_CNT), .W(ADDR_W)) u_raddr (
        .clk   (sclk),
        .rst_n (rst_n),
        .clr   (rd_frame_start),
        .inc   (rd_gnt),
        .addr  (raddr)
    );

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (wr_gnt) begin
            unique case (state)
                ST_IDLE: state_d = last_pix ? ST_SHOW : ST_LOAD;
                ST_LOAD: state_d = last_pix ? ST_SHOW : ST_LOAD;
                ST_SHOW: state_d = ST_LOAD;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            frame_done <= 1'b0;
        end else begin
            ram_en     <= rd_gnt | wr_gnt;
            ram_we     <= wr_gnt;
            ram_addr   <= rd_gnt ? raddr : waddr;
            frame_done <= wr_gnt & last_pix;
            if (wr_gnt) begin
                ram_wdata <= wr_data;
            end
        end
    end

    // Blanking follows the state at grant time, not at data return.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            shw_q    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            vld_q    <= {vld_q[0], rd_gnt};
            shw_q    <= {shw_q[0], rd_gnt & (state == ST_SHOW)};
            rd_valid <= vld_q[1];
            rd_data  <= shw_q[1] ? ram_rdata : '0;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            wr_starve  <= 1'b0;
        end else if (wr_gnt) begin
            starve_cnt <= '0;
        end else if (wr_req) begin
            if (starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (starve_cnt >= SW'(STARVE_MAX - 1)) begin
                wr_starve <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_ram_sched.sv
// Directed bench for frame_ram_sched with a 4x2 frame and STARVE_MAX=4.
// A behavioural single-port RAM answers one cycle after ram_en.
module tb_frame_ram_sched;

    logic        sclk;
    logic        rst_n;
    logic        wr_req;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        rd_frame_start;
    logic        rd_req;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        ram_en;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        frame_done;
    logic        wr_starve;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    logic [7:0] mem [0:15];

    frame_ram_sched #(
        .IMG_W(4), .IMG_H(2), .ADDR_W(14), .DATA_W(8), .STARVE_MAX(4)
    ) dut (
        .sclk           (sclk),
        .rst_n          (rst_n),
        .wr_req         (wr_req),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .rd_frame_start (rd_frame_start),
        .rd_req         (rd_req),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .ram_en         (ram_en),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .frame_done     (frame_done),
        .wr_starve      (wr_starve)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    always @(posedge sclk) begin
        if (ram_en && ram_we) mem[ram_addr[3:0]] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hAA;
        ram_rdata      = 8'h00;
        rst_n          = 1'b0;
        wr_req         = 1'b0;
        wr_data        = 8'h00;
        rd_req         = 1'b0;
        rd_frame_start = 1'b0;
        repeat (3) tick();

        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 14'd0);
        chk("rst_ram_wdata", ram_wdata, 8'h00);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_wr_starve", wr_starve, 1'b0);
        chk("rst_wr_ack", wr_ack, 1'b0);
        rst_n = 1'b1;
        repeat (6) tick();

        // 1: read while IDLE is blanked
        rd_req = 1'b1;
        tick();
        chk("t1_ram_en", ram_en, 1'b1);
        chk("t1_ram_we", ram_we, 1'b0);
        chk("t1_ram_addr", ram_addr, 14'd0);
        rd_req = 1'b0;
        tick();
        chk("t1_valid_n2", rd_valid, 1'b0);
        tick();
        chk("t1_valid_n3", rd_valid, 1'b1);
        chk("t1_data_n3", rd_data, 8'h00);
        tick();
        chk("t1_valid_n4", rd_valid, 1'b0);

        // 2: one full 4x2 frame of writes
        for (int i = 0; i < 8; i++) begin
            wr_req  = 1'b1;
            wr_data = 8'h10 + 8'(i);
            #1;
            chk("t2_wr_ack", wr_ack, 1'b1);
            tick();
            chk("t2_ram_en", ram_en, 1'b1);
            chk("t2_ram_we", ram_we, 1'b1);
            chk("t2_ram_addr", ram_addr, 14'(i));
            chk("t2_ram_wdata", ram_wdata, 8'h10 + 8'(i));
            chk("t2_frame_done", frame_done, (i == 7) ? 1'b1 : 1'b0);
            if (frame_done) fd_cnt++;
        end
        wr_req = 1'b0;
        tick();
        chk("t2_idle_en", ram_en, 1'b0);
        chk("t2_fd_after", frame_done, 1'b0);
        chk("t2_fd_count", fd_cnt, 1);

        // 3: frame start plus four reads in SHOW
        for (int k = 0; k < 6; k++) begin
            rd_req         = (k < 4);
            rd_frame_start = (k == 0);
            tick();
            if (k < 4) chk("t3_ram_addr", ram_addr, 14'(k));
            if (k >= 2) begin
                chk("t3_rd_valid", rd_valid, 1'b1);
                chk("t3_rd_data", rd_data, 8'h10 + 8'(k - 2));
            end
        end
        rd_req = 1'b0;
        tick();
        chk("t3_valid_end", rd_valid, 1'b0);

        // 4: read beats write; write goes the cycle reads stop
        wr_req  = 1'b1;
        wr_data = 8'h20;
        rd_req  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_wr_ack_blk", wr_ack, 1'b0);
            tick();
            chk("t4_rd_we", ram_we, 1'b0);
            chk("t4_rd_addr", ram_addr, 14'(4 + k));
        end
        rd_req = 1'b0;
        #1;
        chk("t4_wr_ack", wr_ack, 1'b1);
        tick();
        chk("t4_wr_we", ram_we, 1'b1);
        chk("t4_wr_addr", ram_addr, 14'd0);
        chk("t4_wr_wdata", ram_wdata, 8'h20);
        chk("t4_rd_data5", rd_data, 8'h15);
        wr_req = 1'b0;
        tick();
        chk("t4_rd_data6", rd_data, 8'h16);
        chk("t4_starve", wr_starve, 1'b0);
        tick();

        // 5: starvation under continuous reads (now in LOAD)
        wr_req  = 1'b1;
        wr_data = 8'h21;
        rd_req  = 1'b1;
        repeat (3) tick();
        chk("t5_starve_3", wr_starve, 1'b0);
        tick();
        chk("t5_starve_4", wr_starve, 1'b1);
        chk("t5_load_valid", rd_valid, 1'b1);
        chk("t5_load_blank", rd_data, 8'h00);
        rd_req = 1'b0;
        tick();
        chk("t5_wr_addr", ram_addr, 14'd1);
        chk("t5_wr_we", ram_we, 1'b1);
        wr_req = 1'b0;
        tick();
        chk("t5_starve_sticky", wr_starve, 1'b1);

        // 6: reset with reads in flight
        rd_req = 1'b1;
        repeat (2) tick();
        rd_req = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("t6_rst_valid", rd_valid, 1'b0);
        chk("t6_rst_en", ram_en, 1'b0);
        chk("t6_rst_starve", wr_starve, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_no_valid", rd_valid, 1'b0);
        end
        rd_req = 1'b1;
        tick();
        chk("t6_raddr0", ram_addr, 14'd0);
        rd_req  = 1'b0;
        wr_req  = 1'b1;
        wr_data = 8'h33;
        tick();
        chk("t6_waddr0", ram_addr, 14'd0);
        chk("t6_we", ram_we, 1'b1);
        chk("t6_idle_blank", rd_data, 8'h00);
        wr_req = 1'b0;
        tick();
        chk("t6_blank_valid", rd_valid, 1'b1);
        chk("t6_blank_data", rd_data, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
